// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared constants, state encoding and helpers for the RV32M execute unit
// Contents: RV32M opcode/func7 values, func3 M-op selects, DIV_CYCLES,
//           FSM state encoding, operand magnitude helper.
package ex_muldiv_pkg;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Unsigned magnitude of a value that is two's complement when is_signed is set.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed & x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/ex_div_core.sv
// rtl/ex_div_core.sv - radix-2 restoring divider datapath with sign fix-up
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            capture operand magnitudes and result signs, clear remainder
//   step            perform one restoring iteration (one quotient bit)
//   is_signed       operands are two's complement (sampled on load)
//   dividend        raw op1 (sampled on load)
//   divisor         raw op2 (sampled on load)
//   quotient        sign-corrected quotient after the current cycle's step
//   remainder       sign-corrected remainder after the current cycle's step
module ex_div_core
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic [32:0] shifted;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  assign shifted  = {rem_q, quo_q[31]};
  assign fits     = shifted >= {1'b0, dvs_q};
  // When fits is set the difference is below the divisor, so 32 bits suffice.
  assign rem_next = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
  assign quo_next = {quo_q[30:0], fits};

  // Outputs reflect this cycle's step so the caller can latch them on the last one.
  assign quotient  = neg_quo_q ? (32'd0 - quo_next) : quo_next;
  assign remainder = neg_rem_q ? (32'd0 - rem_next) : rem_next;

  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (load) begin
      rem_d     = '0;
      quo_d     = mag32(dividend, is_signed);
      dvs_d     = mag32(divisor, is_signed);
      neg_quo_d = is_signed & (dividend[31] ^ divisor[31]);
      neg_rem_d = is_signed & dividend[31];
    end else if (step) begin
      rem_d = rem_next;
      quo_d = quo_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M multiply/divide execute unit with pipeline stall control
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        EX-stage instruction is an M-op (held while ID/EX is stalled)
//   func3        M-op select
//   op1, op2     forwarded rs1/rs2 operands
//   flush        synchronous abort of the in-flight op
//   stall_req    freeze PC, IF/ID and ID/EX
//   done         one-cycle result-valid pulse
//   result       M-op result, held until the next done
//   busy         unit is not idle
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        flush,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] result,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] result_q, result_d;

  logic        capture;
  logic        is_div;
  logic        div_signed;
  logic        div_by_zero;
  logic        div_ovf;
  logic        div_special;
  logic [31:0] special_res;
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] mul_res;
  logic [31:0] div_quo, div_rem, div_res;
  logic        div_step;
  logic        div_last;

  assign capture     = (state_q == ST_IDLE) & start & ~flush;
  assign is_div      = func3[2];
  assign div_signed  = ~func3[0];
  assign div_by_zero = (op2 == 32'd0);
  assign div_ovf     = div_signed & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);
  assign div_special = div_by_zero | div_ovf;

  // Special divides resolve at capture: REM/REMU (func3[1]) yield the dividend
  // on divide-by-zero and zero on overflow; DIV/DIVU yield all-ones or INT_MIN.
  assign special_res = func3[1] ? (div_by_zero ? op1 : 32'd0)
                                : (div_by_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

  // 64-bit wrap-around product of extended operands gives the exact low 64 bits
  // of the signed/unsigned product for every M-op flavour.
  assign mul_a   = {{32{op1_q[31] & ((func3_q == F3_MULH) | (func3_q == F3_MULHSU))}}, op1_q};
  assign mul_b   = {{32{op2_q[31] & (func3_q == F3_MULH)}}, op2_q};
  assign product = mul_a * mul_b;
  assign mul_res = (func3_q == F3_MUL) ? product[31:0] : product[63:32];

  assign div_step = (state_q == ST_DIV);
  assign div_last = (cnt_q == 6'(DIV_CYCLES - 1));
  assign div_res  = func3_q[1] ? div_rem : div_quo;

  ex_div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .step      (div_step),
    .is_signed (div_signed),
    .dividend  (op1),
    .divisor   (op2),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          func3_d = func3;
          op1_d   = op1;
          op2_d   = op2;
          cnt_d   = '0;
          if (!is_div) begin
            state_d = ST_MUL;
          end else if (div_special) begin
            state_d  = ST_DONE;
            result_d = special_res;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        state_d  = ST_DONE;
        result_d = mul_res;
      end
      ST_DIV: begin
        cnt_d = cnt_q + 6'd1;
        if (div_last) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = div_res;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Redirect wins over everything: drop the op and keep the last result.
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
    end
  end

  // The IDLE term stalls the pipeline in the capture cycle itself; reset
  // forces it low because start may still be high from the frozen ID/EX.
  assign stall_req = ~rst & (((state_q == ST_IDLE) & start & ~flush)
                             | (state_q == ST_MUL) | (state_q == ST_DIV));
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit against a latency/arithmetic model
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic        done;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  int done_cnt = 0;

  ex_muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .func3     (func3),
    .op1       (op1),
    .op2       (op2),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an RV32M op, from plain integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    bit ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from capture to the done cycle.
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f < 3'd4) return 2;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Model: cycles left until done, done-cycle flag, visible result.
  int          m_left;
  bit          m_done;
  logic [31:0] m_result;
  logic [31:0] m_pending;
  int          nx_left;
  bit          nx_done;
  logic [31:0] nx_result;
  logic [31:0] nx_pending;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   <= 0;
      m_done   <= 1'b0;
      m_result <= 32'd0;
    end else begin
      nx_left    = m_left;
      nx_done    = 1'b0;
      nx_result  = m_result;
      nx_pending = m_pending;
      if (m_done) begin
        nx_left = 0;
      end else if (m_left > 0) begin
        if (flush) begin
          nx_left = 0;
        end else begin
          nx_left = m_left - 1;
          if (nx_left == 0) begin
            nx_done   = 1'b1;
            nx_result = m_pending;
          end
        end
      end else if (start && !flush) begin
        nx_pending = ref_op(func3, op1, op2);
        nx_left    = ref_lat(func3, op1, op2) - 1;
        if (nx_left == 0) begin
          nx_done   = 1'b1;
          nx_result = nx_pending;
        end
      end
      m_left    <= nx_left;
      m_done    <= nx_done;
      m_result  <= nx_result;
      m_pending <= nx_pending;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("done", 32'(done), 32'(m_done));
      check("busy", 32'(busy), 32'((m_left > 0) || m_done));
      check("stall_req", 32'(stall_req),
            32'(!rst && ((m_left > 0) || (m_left == 0 && !m_done && start && !flush))));
      check("result", result, m_result);
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one M-op and hold it like a stalled ID/EX until it advances.
  // flush_at >= 0 raises flush in that cycle after issue; n is the done-cycle offset or -1.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int n, output logic [31:0] res);
    bit seen;
    int cyc;
    start = 1'b1;
    func3 = f;
    op1   = a;
    op2   = b;
    n     = -1;
    res   = 32'd0;
    cyc   = 0;
    forever begin
      if (cyc == flush_at) flush = 1'b1;
      @(negedge clk);
      seen = done;
      if (seen) res = result;
      tick();
      if (flush) begin
        flush = 1'b0;
        start = 1'b0;
        return;
      end
      if (seen) begin
        n = cyc;
        return;
      end
      // Inputs after capture must not disturb the in-flight op.
      func3 = 3'($urandom);
      op1   = $urandom;
      op2   = $urandom;
      cyc++;
      if (cyc > 40) begin
        checks++;
        errors++;
        $display("FAIL timeout waiting for done f3=%0d op1=%h op2=%h", f, a, b);
        start = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int          n;
    int          lat;
    int          fa;
    int          dc;
    logic [2:0]  f;
    logic [31:0] a, b, r;

    // Pin the reference model with hand-computed values.
    check("pin_mul",    ref_op(3'd0, 32'hFFFF_FFFF, 32'd7), 32'hFFFF_FFF9);
    check("pin_mulhu",  ref_op(3'd3, 32'hFFFF_FFFF, 32'd7), 32'h0000_0006);
    check("pin_div",    ref_op(3'd4, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFA);
    check("pin_rem",    ref_op(3'd6, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
    check("pin_divu0",  ref_op(3'd5, 32'd100, 32'd0), 32'hFFFF_FFFF);
    check("pin_remu0",  ref_op(3'd7, 32'd100, 32'd0), 32'd100);
    check("pin_ovfdiv", ref_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_ovfrem", ref_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    check("pin_mulhsu", ref_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_mulh",   ref_op(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);

    // Reset with a pending M-op on the inputs: everything must read as reset.
    #1;
    rst      = 1'b1;
    check_en = 1'b1;
    start    = 1'b1;
    func3    = 3'd4;
    op1      = 32'd77;
    op2      = 32'd5;
    @(negedge clk);
    check("rst_done",  32'(done), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_result", result, 32'd0);
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();

    run_op(3'd0, 32'hFFFF_FFFF, 32'd7, -1, n, r);
    start = 1'b0;
    check("mul_lat", 32'(n), 32'd2);
    check("mul_res", r, 32'hFFFF_FFF9);
    tick();
    run_op(3'd3, 32'hFFFF_FFFF, 32'd7, -1, n, r);
    start = 1'b0;
    check("mulhu_res", r, 32'h0000_0006);
    tick();

    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, -1, n, r);
    start = 1'b0;
    check("div_lat", 32'(n), 32'd33);
    check("div_res", r, 32'hFFFF_FFFA);
    tick();
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, -1, n, r);
    start = 1'b0;
    check("rem_lat", 32'(n), 32'd33);
    check("rem_res", r, 32'hFFFF_FFFE);
    tick();

    run_op(3'd5, 32'd100, 32'd0, -1, n, r);
    start = 1'b0;
    check("divu0_lat", 32'(n), 32'd1);
    check("divu0_res", r, 32'hFFFF_FFFF);
    tick();
    run_op(3'd7, 32'd100, 32'd0, -1, n, r);
    start = 1'b0;
    check("remu0_res", r, 32'd100);
    tick();

    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, n, r);
    start = 1'b0;
    check("ovf_lat", 32'(n), 32'd1);
    check("ovf_res", r, 32'h8000_0000);
    tick();
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, n, r);
    start = 1'b0;
    check("ovfrem_res", r, 32'd0);
    tick();

    // Back-to-back with start held: exactly two done pulses.
    dc = done_cnt;
    run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, n, r);
    check("b2b_mulhsu", r, 32'hFFFF_FFFE);
    run_op(3'd0, 32'd3, 32'd5, -1, n, r);
    start = 1'b0;
    check("b2b_mul", r, 32'h0000_000F);
    repeat (3) tick();
    check("b2b_done_count", 32'(done_cnt - dc), 32'd2);

    // Flush a DIVU at T+10: idle at T+11, no done, result unchanged.
    dc = done_cnt;
    run_op(3'd5, 32'd1000, 32'd7, 10, n, r);
    @(negedge clk);
    check("flush_no_done", 32'(n), 32'hFFFF_FFFF);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_stall", 32'(stall_req), 32'd0);
    check("flush_result", result, 32'h0000_000F);
    check("flush_done_count", 32'(done_cnt - dc), 32'd0);
    tick();

    // Reset at T+5 of a DIV: outputs return to reset values at once.
    start = 1'b1;
    func3 = 3'd4;
    op1   = 32'hFFFF_FFEC;
    op2   = 32'd3;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("rstmid_done",   32'(done), 32'd0);
    check("rstmid_busy",   32'(busy), 32'd0);
    check("rstmid_stall",  32'(stall_req), 32'd0);
    check("rstmid_result", result, 32'd0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 80; i++) begin
      f = 3'($urandom);
      case ($urandom_range(0, 7))
        0:       begin a = $urandom; b = 32'd0; end
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin a = 32'($signed($urandom_range(0, 200)) - 100); b = $urandom_range(1, 9); end
        3:       begin a = $urandom; b = 32'hFFFF_FFFF; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      lat = ref_lat(f, a, b);
      fa  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
      run_op(f, a, b, fa, n, r);
      if (fa < 0) begin
        check("rand_lat", 32'(n), 32'(lat));
        check("rand_res", r, ref_op(f, a, b));
      end
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    start = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
